// File: rtl/wheel_rotation_scheduler.sv
// Sequences angle moves for NUM_CH swerve-wheel rotation controllers and caps simultaneous moves at MAX_ACTIVE.
// Latency: a command accepted at edge E0 issues at E1 at the earliest; done, stall and timeout act on their sampling edge.
// Backpressure: cmd_ready drops while the wheel's pending slot is full, the wheel is faulted, or abort_all is high.
module wheel_rotation_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int MAX_ACTIVE = 2,
  parameter int GUARD      = 4,
  parameter int TMO_W      = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_ch,
  input  logic [11:0]           cmd_angle,
  output logic                  cmd_ready,
  input  logic                  abort_all,
  input  logic [TMO_W-1:0]      timeout_cycles,
  input  logic [NUM_CH-1:0]     fault_clr,
  input  logic [NUM_CH-1:0]     angle_done,
  input  logic [NUM_CH-1:0]     stalled,
  output logic [12*NUM_CH-1:0]  target_angle,
  output logic [NUM_CH-1:0]     angle_update,
  output logic [NUM_CH-1:0]     pwm_enable,
  output logic [NUM_CH-1:0]     abort_angle,
  output logic [NUM_CH-1:0]     busy,
  output logic [NUM_CH-1:0]     fault,
  output logic [NUM_CH-1:0]     fault_stall,
  output logic                  all_idle
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(NUM_CH + 1);
  localparam int GRD_W = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVING,
    ST_FAULT
  } wheel_st_t;

  wheel_st_t         state      [NUM_CH];
  logic [11:0]       pend_angle [NUM_CH];
  logic [11:0]       tgt_q      [NUM_CH];
  logic [GRD_W-1:0]  guard_cnt  [NUM_CH];
  logic [TMO_W-1:0]  tmo_cnt    [NUM_CH];
  logic [NUM_CH-1:0] pend_v;
  logic [NUM_CH-1:0] fault_stall_q;
  logic [NUM_CH-1:0] upd_q;
  logic [NUM_CH-1:0] abort_q;
  logic [CH_W-1:0]   rr_ptr;

  logic [NUM_CH-1:0] moving;
  logic [NUM_CH-1:0] faulted;
  logic [NUM_CH-1:0] cand;
  logic [CNT_W-1:0]  active_cnt;
  logic              issue_vld;
  logic [CH_W-1:0]   issue_ch;
  logic [CH_W-1:0]   idx;
  logic              cmd_acc;

  // Decode per-wheel status and count wheels currently drawing motor current
  always_comb begin
    active_cnt = '0;
    moving     = '0;
    faulted    = '0;
    cand       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      moving[i]  = (state[i] == ST_MOVING);
      faulted[i] = (state[i] == ST_FAULT);
      cand[i]    = (state[i] == ST_IDLE) && pend_v[i];
      active_cnt = active_cnt + CNT_W'(moving[i]);
    end
  end

  // Round-robin pick of one eligible wheel starting at rr_ptr; descending scan so the nearest wins
  always_comb begin
    issue_vld = 1'b0;
    issue_ch  = '0;
    idx       = '0;
    if (!abort_all && (active_cnt < CNT_W'(MAX_ACTIVE))) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
        if (cand[idx]) begin
          issue_vld = 1'b1;
          issue_ch  = idx;
        end
      end
    end
  end

  assign cmd_ready = ~pend_v[cmd_ch] & ~faulted[cmd_ch] & ~abort_all;
  assign cmd_acc   = cmd_valid & cmd_ready;

  // Per-wheel move FSM, pending slots, supervision counters and one-cycle pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i]      <= ST_IDLE;
        pend_angle[i] <= '0;
        tgt_q[i]      <= '0;
        guard_cnt[i]  <= '0;
        tmo_cnt[i]    <= '0;
      end
      pend_v        <= '0;
      fault_stall_q <= '0;
      upd_q         <= '0;
      abort_q       <= '0;
      rr_ptr        <= '0;
    end else begin
      upd_q   <= '0;
      abort_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        case (state[i])
          ST_IDLE: begin
            if (issue_vld && (int'(issue_ch) == i)) begin
              state[i]     <= ST_MOVING;
              tgt_q[i]     <= pend_angle[i];
              guard_cnt[i] <= GRD_W'(GUARD);
              tmo_cnt[i]   <= '0;
              upd_q[i]     <= 1'b1;
            end
          end
          ST_MOVING: begin
            if (guard_cnt[i] != '0) guard_cnt[i] <= guard_cnt[i] - GRD_W'(1);
            if (tmo_cnt[i] != '1) tmo_cnt[i] <= tmo_cnt[i] + TMO_W'(1);
            // Exit priority: global abort, stall, timeout, then a done seen after the guard window
            if (abort_all) begin
              state[i]   <= ST_IDLE;
              abort_q[i] <= 1'b1;
            end else if (stalled[i]) begin
              state[i]         <= ST_FAULT;
              fault_stall_q[i] <= 1'b1;
              abort_q[i]       <= 1'b1;
            end else if ((timeout_cycles != '0) && (tmo_cnt[i] == timeout_cycles)) begin
              state[i]         <= ST_FAULT;
              fault_stall_q[i] <= 1'b0;
              abort_q[i]       <= 1'b1;
            end else if ((guard_cnt[i] == '0) && angle_done[i]) begin
              state[i] <= ST_IDLE;
            end
          end
          ST_FAULT: begin
            if (fault_clr[i]) begin
              state[i]         <= ST_IDLE;
              fault_stall_q[i] <= 1'b0;
            end
          end
          default: state[i] <= ST_IDLE;
        endcase

        // Pending slot: abort flushes, issue drains, acceptance fills (never coincident with issue)
        if (abort_all) begin
          pend_v[i] <= 1'b0;
        end else if (issue_vld && (int'(issue_ch) == i)) begin
          pend_v[i] <= 1'b0;
        end else if (cmd_acc && (int'(cmd_ch) == i)) begin
          pend_v[i]     <= 1'b1;
          pend_angle[i] <= cmd_angle;
        end
      end
      if (issue_vld) rr_ptr <= CH_W'((int'(issue_ch) + 1) % NUM_CH);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_tgt
    assign target_angle[12*g +: 12] = tgt_q[g];
  end

  assign angle_update = upd_q;
  assign abort_angle  = abort_q;
  assign pwm_enable   = moving;
  assign busy         = moving;
  assign fault        = faulted;
  assign fault_stall  = fault_stall_q;
  assign all_idle     = ~|pend_v & ~|moving;

endmodule

// File: tb/tb_wheel_rotation_scheduler.sv
// Bench for wheel_rotation_scheduler: a vector table, directed corner sequences and random traffic,
// all compared every cycle against a reference model that tracks moves by elapsed edges since issue.
module tb_wheel_rotation_scheduler;

  localparam int NUM_CH     = 4;
  localparam int MAX_ACTIVE = 2;
  localparam int GUARD      = 4;
  localparam int TMO_W      = 24;

  logic              clock = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic [1:0]        cmd_ch;
  logic [11:0]       cmd_angle;
  logic              cmd_ready;
  logic              abort_all;
  logic [TMO_W-1:0]  timeout_cycles;
  logic [3:0]        fault_clr;
  logic [3:0]        angle_done;
  logic [3:0]        stalled;
  logic [47:0]       target_angle;
  logic [3:0]        angle_update;
  logic [3:0]        pwm_enable;
  logic [3:0]        abort_angle;
  logic [3:0]        busy;
  logic [3:0]        fault;
  logic [3:0]        fault_stall;
  logic              all_idle;

  always #5 clock = ~clock;

  wheel_rotation_scheduler #(
    .NUM_CH(NUM_CH), .MAX_ACTIVE(MAX_ACTIVE), .GUARD(GUARD), .TMO_W(TMO_W)
  ) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch),
    .cmd_angle(cmd_angle), .cmd_ready(cmd_ready), .abort_all(abort_all),
    .timeout_cycles(timeout_cycles), .fault_clr(fault_clr), .angle_done(angle_done),
    .stalled(stalled), .target_angle(target_angle), .angle_update(angle_update),
    .pwm_enable(pwm_enable), .abort_angle(abort_angle), .busy(busy), .fault(fault),
    .fault_stall(fault_stall), .all_idle(all_idle)
  );

  int n_total = 0;
  int n_pass  = 0;
  int upd_log[$];

  // Reference model: per-wheel flags plus the edge number at which each move was issued
  bit          m_moving [NUM_CH];
  bit          m_fault  [NUM_CH];
  bit          m_fstall [NUM_CH];
  bit          m_pend   [NUM_CH];
  logic [11:0] m_pang   [NUM_CH];
  logic [11:0] m_tgt    [NUM_CH];
  int          m_issue  [NUM_CH];
  logic [3:0]  e_upd;
  logic [3:0]  e_abrt;
  int          m_rr;
  int          cyc = 0;

  typedef struct {
    logic       cv;
    logic [1:0] ch;
    logic [11:0] ang;
    logic [3:0] done;
    logic [3:0] stall;
    logic [3:0] clr;
    logic       rdy;
    logic [3:0] busy;
    logic [3:0] upd;
    logic [3:0] abrt;
    logic [3:0] flt;
    logic [3:0] fst;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, want, $time);
  endtask

  function automatic bit m_ready();
    return !m_pend[cmd_ch] && !m_fault[cmd_ch] && !abort_all;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_moving[i] = 0; m_fault[i] = 0; m_fstall[i] = 0; m_pend[i] = 0;
      m_pang[i] = '0; m_tgt[i] = '0; m_issue[i] = 0;
    end
    e_upd = '0; e_abrt = '0; m_rr = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    int n_mov = 0;
    int pick  = -1;
    int k;
    bit acc;
    for (int i = 0; i < NUM_CH; i++) n_mov += int'(m_moving[i]);
    if (!abort_all && n_mov < MAX_ACTIVE) begin
      for (int j = 0; j < NUM_CH; j++) begin
        int c;
        c = (m_rr + j) % NUM_CH;
        if (pick < 0 && m_pend[c] && !m_moving[c] && !m_fault[c]) pick = c;
      end
    end
    acc = cmd_valid && m_ready();
    cyc++;
    e_upd = '0; e_abrt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_moving[i]) begin
        k = cyc - m_issue[i];  // edges since issue, this one included; counter value is k-1
        if (abort_all) begin
          m_moving[i] = 0; e_abrt[i] = 1;
        end else if (stalled[i]) begin
          m_moving[i] = 0; m_fault[i] = 1; m_fstall[i] = 1; e_abrt[i] = 1;
        end else if (timeout_cycles != 0 && (k - 1) == int'(timeout_cycles)) begin
          m_moving[i] = 0; m_fault[i] = 1; m_fstall[i] = 0; e_abrt[i] = 1;
        end else if (k > GUARD && angle_done[i]) begin
          m_moving[i] = 0;
        end
      end else if (m_fault[i] && fault_clr[i]) begin
        m_fault[i] = 0; m_fstall[i] = 0;
      end
    end
    if (pick >= 0) begin
      m_moving[pick] = 1; m_issue[pick] = cyc; m_tgt[pick] = m_pang[pick];
      m_pend[pick] = 0; e_upd[pick] = 1; m_rr = (pick + 1) % NUM_CH;
    end
    if (abort_all) begin
      for (int i = 0; i < NUM_CH; i++) m_pend[i] = 0;
    end else if (acc) begin
      m_pend[cmd_ch] = 1; m_pang[cmd_ch] = cmd_angle;
    end
  endtask

  task automatic check_outputs();
    logic [3:0]  eb, ef, es;
    logic [47:0] et;
    bit          idle;
    idle = 1;
    for (int i = 0; i < NUM_CH; i++) begin
      eb[i] = m_moving[i]; ef[i] = m_fault[i]; es[i] = m_fstall[i];
      et[12*i +: 12] = m_tgt[i];
      if (m_moving[i] || m_pend[i]) idle = 0;
    end
    chk("busy", busy, eb);
    chk("pwm_enable", pwm_enable, eb);
    chk("fault", fault, ef);
    chk("fault_stall", fault_stall, es);
    chk("angle_update", angle_update, e_upd);
    chk("abort_angle", abort_angle, e_abrt);
    chk("target_angle", target_angle, et);
    chk("all_idle", all_idle, idle);
  endtask

  // One clock: check the combinational ready, advance model and DUT, compare everything
  task automatic step();
    #1;
    chk("cmd_ready", cmd_ready, m_ready());
    model_step();
    @(posedge clock);
    #1;
    check_outputs();
    for (int i = 0; i < NUM_CH; i++) if (angle_update[i]) upd_log.push_back(i);
  endtask

  task automatic clear_inputs();
    cmd_valid = 0; cmd_ch = '0; cmd_angle = '0; abort_all = 0;
    fault_clr = '0; angle_done = '0; stalled = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    @(posedge clock);
    #1;
    model_reset();
    check_outputs();
    reset = 0;
  endtask

  initial begin
    int busy_cycles;
    int edges;
    int order;

    // cv ch ang | done stall clr | rdy busy upd abrt flt fst
    vt[0]  = '{1'b1, 2'd2, 12'h123, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[1]  = '{1'b0, 2'd0, 12'h000, 4'h0, 4'h0, 4'h0, 1'b1, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0};
    vt[2]  = '{1'b0, 2'd0, 12'h000, 4'h0, 4'h0, 4'h0, 1'b1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[3]  = '{1'b0, 2'd0, 12'h000, 4'h0, 4'h0, 4'h0, 1'b1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[4]  = '{1'b0, 2'd0, 12'h000, 4'h0, 4'h0, 4'h0, 1'b1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[5]  = '{1'b0, 2'd0, 12'h000, 4'h0, 4'h0, 4'h0, 1'b1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[6]  = '{1'b0, 2'd0, 12'h000, 4'h4, 4'h4, 4'h0, 1'b1, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4};
    vt[7]  = '{1'b1, 2'd2, 12'h456, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4};
    vt[8]  = '{1'b0, 2'd0, 12'h000, 4'h0, 4'h0, 4'h4, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[9]  = '{1'b1, 2'd2, 12'h0AB, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[10] = '{1'b0, 2'd0, 12'h000, 4'h0, 4'h0, 4'h0, 1'b1, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0};
    vt[11] = '{1'b0, 2'd0, 12'h000, 4'h0, 4'h4, 4'h4, 1'b1, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4};
    vt[12] = '{1'b0, 2'd0, 12'h000, 4'h0, 4'h0, 4'h4, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

    timeout_cycles = '0;
    do_reset();
    chk("rst_all_idle", all_idle, 1'b1);
    chk("rst_ready", cmd_ready, 1'b1);

    // Vector table: issue, stall beating done, fault blocking commands, clear ignored on fault entry
    for (int r = 0; r < 13; r++) begin
      cmd_valid = vt[r].cv; cmd_ch = vt[r].ch; cmd_angle = vt[r].ang;
      angle_done = vt[r].done; stalled = vt[r].stall; fault_clr = vt[r].clr;
      #1;
      chk($sformatf("vec%0d_ready", r), cmd_ready, vt[r].rdy);
      step();
      chk($sformatf("vec%0d_busy", r), busy, vt[r].busy);
      chk($sformatf("vec%0d_upd", r), angle_update, vt[r].upd);
      chk($sformatf("vec%0d_abrt", r), abort_angle, vt[r].abrt);
      chk($sformatf("vec%0d_fault", r), fault, vt[r].flt);
      chk($sformatf("vec%0d_fstall", r), fault_stall, vt[r].fst);
    end
    clear_inputs();

    // Single move: done arrives 50 cycles after the issue pulse
    cmd_valid = 1; cmd_ch = 2'd1; cmd_angle = 12'd300;
    step();
    cmd_valid = 0;
    step();
    chk("single_upd", angle_update, 4'b0010);
    chk("single_tgt", target_angle[23:12], 12'd300);
    busy_cycles = busy[1] ? 1 : 0;
    for (int n = 0; n < 50; n++) begin
      step();
      if (busy[1]) busy_cycles++;
    end
    angle_done[1] = 1;
    step();
    if (busy[1]) busy_cycles++;
    angle_done[1] = 0;
    chk("single_busy_cycles", busy_cycles, 51);
    chk("single_all_idle", all_idle, 1'b1);

    // Concurrency cap of two and round-robin issue order
    upd_log.delete();
    for (int w = 0; w < 4; w++) begin
      cmd_valid = 1; cmd_ch = 2'(w); cmd_angle = 12'(100 + w);
      step();
    end
    cmd_valid = 0;
    repeat (6) step();
    chk("conc_busy", busy, 4'b0011);
    angle_done = 4'b0001; step(); angle_done = 4'b0000; step();
    chk("conc_third", angle_update, 4'b0100);
    angle_done = 4'b0010; step(); angle_done = 4'b0000; step();
    chk("conc_fourth", angle_update, 4'b1000);
    repeat (5) step();
    angle_done = 4'b1100; step(); angle_done = 4'b0000; step();
    order = (upd_log.size() == 4) ?
            (upd_log[0] * 1000 + upd_log[1] * 100 + upd_log[2] * 10 + upd_log[3]) : -1;
    chk("conc_order", order, 123);
    chk("conc_all_idle", all_idle, 1'b1);

    // Timeout: counter starts at 0 on the issue edge, so count 100 is compared on edge 101
    timeout_cycles = 24'd100;
    cmd_valid = 1; cmd_ch = 2'd3; cmd_angle = 12'hABC;
    step();
    cmd_valid = 0;
    step();
    edges = 0;
    while (abort_angle[3] !== 1'b1 && edges < 200) begin
      step();
      edges++;
    end
    chk("tmo_edges", edges, 101);
    chk("tmo_fault", fault[3], 1'b1);
    chk("tmo_fault_stall", fault_stall[3], 1'b0);
    cmd_valid = 1; cmd_ch = 2'd3; cmd_angle = 12'h111;
    #1;
    chk("tmo_ready_blocked", cmd_ready, 1'b0);
    step();
    cmd_valid = 0; fault_clr = 4'b1000;
    step();
    fault_clr = 4'b0000;
    chk("tmo_cleared", fault[3], 1'b0);
    timeout_cycles = '0;

    // Stale done held high across the issue completes only on the fifth edge
    angle_done = 4'b0001; cmd_valid = 1; cmd_ch = 2'd0; cmd_angle = 12'h7FF;
    step();
    cmd_valid = 0;
    step();
    chk("stale_issue", angle_update[0], 1'b1);
    edges = 0;
    while (busy[0] === 1'b1 && edges < 20) begin
      step();
      edges++;
    end
    chk("stale_done_edge", edges, 5);
    angle_done = 4'b0000;

    // abort_all with two wheels moving, one pending and one wheel already faulted
    cmd_valid = 1; cmd_ch = 2'd0; cmd_angle = 12'h010;
    step();
    cmd_valid = 0;
    step();
    stalled = 4'b0001; step(); stalled = 4'b0000;
    chk("abort_pre_fault", fault, 4'b0001);
    for (int w = 1; w < 4; w++) begin
      cmd_valid = 1; cmd_ch = 2'(w); cmd_angle = 12'(w * 16);
      step();
    end
    cmd_valid = 0;
    step();
    chk("abort_pre_busy", busy, 4'b0110);
    abort_all = 1; step(); abort_all = 0;
    chk("abort_pulses", abort_angle, 4'b0110);
    chk("abort_all_idle", all_idle, 1'b1);
    chk("abort_fault_kept", fault, 4'b0001);
    step();
    chk("abort_no_issue", angle_update, 4'b0000);
    fault_clr = 4'b0001; step(); fault_clr = 4'b0000;

    // Reset in the middle of a move: no abort pulse, outputs back to reset values
    cmd_valid = 1; cmd_ch = 2'd3; cmd_angle = 12'h3C3;
    step();
    cmd_valid = 0;
    step();
    step();
    chk("midrst_busy", busy[3], 1'b1);
    do_reset();
    chk("midrst_abort", abort_angle, 4'b0000);
    chk("midrst_tgt", target_angle, 48'h0);

    // Random traffic against the model
    for (int n = 0; n < 2500; n++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_ch    = 2'($urandom_range(0, 3));
      cmd_angle = 12'($urandom);
      for (int i = 0; i < NUM_CH; i++) begin
        angle_done[i] = ($urandom_range(0, 7) == 0);
        stalled[i]    = ($urandom_range(0, 63) == 0);
        fault_clr[i]  = ($urandom_range(0, 5) == 0);
      end
      abort_all = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) timeout_cycles = TMO_W'($urandom_range(0, 30));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wheel_rotation_scheduler.md
# wheel_rotation_scheduler

Sequences angle moves for the four swerve-wheel rotation controllers. Upstream command logic posts per-wheel target angles. The block owns each wheel controller's `target_angle` / `angle_update` / `pwm_enable` / `abort_angle` inputs, and limits how many wheels rotate at once to bound peak motor current. It supervises each move with a timeout and stall check, latches per-wheel faults, and frees the slot when the controller reports `angle_done`.

## Interface
- `NUM_CH`, 4: number of wheel controllers.
- `MAX_ACTIVE`, 2: maximum wheels moving simultaneously (1..`NUM_CH`).
- `GUARD`, 4: cycles after issue during which `angle_done` is ignored.
- `TMO_W`, 24: timeout counter width.

Ports (all synchronous to `clock`):
- `clock`  in  1  main clock
- `reset`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command strobe
- `cmd_ch`  in  2  target wheel index
- `cmd_angle`  in  12  target angle (passed through unchanged)
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`
- `abort_all`  in  1  cancel all moves and pending commands
- `timeout_cycles`  in  `TMO_W`  move timeout; 0 disables the timeout
- `fault_clr`  in  `NUM_CH`  per-wheel fault clear
- `angle_done`  in  `NUM_CH`  level from each wheel controller
- `stalled`  in  `NUM_CH`  level from each wheel controller
- `target_angle`  out  12*`NUM_CH`  flat bus; wheel i at bits [12i+11:12i]
- `angle_update`  out  `NUM_CH`  1-cycle issue pulse
- `pwm_enable`  out  `NUM_CH`  PWM enable per wheel
- `abort_angle`  out  `NUM_CH`  1-cycle abort pulse
- `busy`  out  `NUM_CH`  wheel has a move in flight
- `fault`  out  `NUM_CH`  sticky fault
- `fault_stall`  out  `NUM_CH`  sticky; fault cause was a stall, not a timeout
- `all_idle`  out  1  no pending commands and no moves in flight

## Operation
- Per-wheel state: IDLE, MOVING, FAULT. Each wheel also has a one-entry pending slot (`pend_v`, `pend_angle`).
- `cmd_ready` = `~pend_v[cmd_ch] & ~fault[cmd_ch] & ~abort_all` (combinational).
  - On acceptance: `pend_v` ← 1 and `pend_angle` ← `cmd_angle`.
  - A command to a MOVING wheel waits in the slot. Moves are never preempted.
- Issue arbitration runs every cycle:
  - Condition: `active_cnt < MAX_ACTIVE`.
  - Candidates: wheels in IDLE with `pend_v`=1.
  - Search is round-robin from `rr_ptr`. At most one issue per cycle.
- On issue:
  - `target_angle[ch]` ← `pend_angle`; `pend_v` ← 0.
  - `angle_update[ch]` pulses for 1 cycle.
  - State ← MOVING; guard counter ← `GUARD`; timeout counter ← 0.
  - `rr_ptr` ← ch+1 mod `NUM_CH`.
- MOVING:
  - `pwm_enable`=1 and `busy`=1.
  - The timeout counter increments and saturates.
- MOVING exits, in priority order:
  1. `stalled`=1 → FAULT, with `fault_stall`=1.
  2. Timeout counter == `timeout_cycles` (with `timeout_cycles` ≠ 0) → FAULT, with `fault_stall`=0.
  3. Guard counter == 0 and `angle_done`=1 → IDLE.
  - Entering FAULT pulses `abort_angle[ch]` for 1 cycle and drops `pwm_enable`.
- FAULT:
  - `fault`=1. The pending slot is retained but not issued.
  - `fault_clr[ch]` → IDLE and clears `fault` / `fault_stall`. The pending command then becomes eligible.
- `abort_all` takes priority over everything:
  - Every MOVING wheel gets a 1-cycle `abort_angle` pulse and returns to IDLE.
  - All `pend_v` are cleared. Faults are untouched.
  - No issue occurs in that cycle.
- `active_cnt` = number of wheels in MOVING.
- `all_idle` = no `pend_v` set and no wheel MOVING.

## Timing
- Reset values:
  - All states IDLE; `pend_v`=0; `rr_ptr`=0.
  - `target_angle`=0; `angle_update`, `abort_angle`, `pwm_enable`, `busy`, `fault`, `fault_stall`=0.
  - `all_idle`=1. `cmd_ready` follows its equation (1 whenever `abort_all`=0).
  - Reset asserted mid-move: outputs return to reset values on the next edge. No `abort_angle` pulse is generated.
- Latency:
  - Command accepted at edge E0 → `angle_update` high from E1 if a slot is free and the wheel is IDLE. `target_angle` is valid in the same cycle.
  - `target_angle[ch]` stays stable until the next issue on that wheel.
- Completion:
  - `angle_done` sampled at edge E → `busy` and `pwm_enable` low after E.
  - The freed slot is usable at E+1 (issue visible after E+1).
- Guard: `angle_done` is ignored on the `GUARD` edges following the issue edge. This rejects a stale done level left over from the previous move.
- Simultaneous events:
  - Completion and stall on the same edge → stall wins.
  - `fault_clr` in the same cycle as entering FAULT → fault is set; the clear is ignored.
  - `cmd_valid` for a wheel completing on the same edge → command goes to the pending slot and issues at the earliest the following edge.
- `timeout_cycles` is sampled continuously. Lowering it below the current count causes the timeout to fire when the counter reaches the new value. A counter already past the new value saturates and never fires.

## Test plan
- Single move: cmd wheel 1 to angle 300; `angle_done` goes high 50 cycles after `angle_update` → `angle_update`[1] pulses 1 cycle after acceptance, `target_angle`[23:12]=300, `busy`[1] high 50+1 cycles, `all_idle` returns to 1.
- Concurrency limit (`MAX_ACTIVE`=2): cmds to wheels 0,1,2,3 on consecutive cycles → wheels 0,1 issue; wheel 2 issues the cycle after the first done; wheel 3 after the next done. Round-robin order is preserved.
- Timeout: `timeout_cycles`=100, `angle_done` held low → `abort_angle` pulses at count 100, `fault`=1, `fault_stall`=0, further cmds to that wheel get `cmd_ready`=0 until `fault_clr`.
- Stall vs done: `stalled` and `angle_done` asserted on the same edge → FAULT with `fault_stall`=1, single `abort_angle` pulse.
- Stale done: `angle_done` held high across a new issue → move does not complete before `GUARD`=4 edges; it completes on the 5th edge.
- `abort_all` while 2 wheels are moving and 1 is pending → two `abort_angle` pulses, pending slot cleared, `all_idle`=1 next cycle, faults unchanged.
